// File: rtl/frame_uart_streamer.sv
// Frame packetiser: streams a (optionally decimated) raster over the UART byte interface
// as sync word, dimension header, payload bytes and an 8-bit additive checksum.
module frame_uart_streamer #(
   parameter int WIDTH    = 640,
   parameter int HEIGHT   = 480,
   parameter int CHANNELS = 3,
   parameter int CH_W     = 10,
   parameter int DECIM    = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     abort,
   input  logic [CHANNELS*CH_W-1:0] pix_data,
   input  logic                     pix_valid,
   output logic                     pix_ready,
   output logic [7:0]               tx_data,
   output logic                     tx_start,
   input  logic                     tx_busy,
   input  logic                     tx_done,
   output logic                     busy,
   output logic                     frame_done,
   output logic [2:0]               state
);

   localparam logic [15:0] OW       = 16'(WIDTH / DECIM);
   localparam logic [15:0] OH       = 16'(HEIGHT / DECIM);
   localparam logic [15:0] LAST_COL = 16'(WIDTH - 1);
   localparam logic [15:0] LAST_ROW = 16'(HEIGHT - 1);
   localparam logic [15:0] DMASK    = 16'(DECIM - 1);
   localparam logic [2:0]  LAST_CH  = 3'(CHANNELS - 1);
   localparam logic [7:0]  CH_BYTE  = 8'(CHANNELS);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_HDR   = 3'd1,
      S_FETCH = 3'd2,
      S_PIX   = 3'd3,
      S_CSUM  = 3'd4,
      S_WAIT  = 3'd5,
      S_DONE  = 3'd6
   } state_t;

   state_t                   cur_state;
   state_t                   ret_state;
   logic [15:0]              row;
   logic [15:0]              col;
   logic [2:0]               byte_idx;
   logic [7:0]               checksum;
   logic [CHANNELS*CH_W-1:0] pix_lat;
   logic                     last_pix;
   logic                     start_armed;

   logic [7:0]               hdr_byte;
   logic [7:0]               pix_byte;
   logic [7:0]               send_byte;
   logic                     sum_en;
   logic                     keep_pix;
   logic                     at_last;

   assign state = cur_state;
   assign busy  = (cur_state != S_IDLE);

   always_comb begin
      hdr_byte = CH_BYTE;
      case (byte_idx)
         3'd0:    hdr_byte = 8'hA5;
         3'd1:    hdr_byte = 8'h5A;
         3'd2:    hdr_byte = OW[15:8];
         3'd3:    hdr_byte = OW[7:0];
         3'd4:    hdr_byte = OH[15:8];
         3'd5:    hdr_byte = OH[7:0];
         default: hdr_byte = CH_BYTE;
      endcase
   end

   // Payload goes out highest channel first, each as the top 8 bits of its field
   always_comb begin
      pix_byte = 8'h00;
      for (int c = 0; c < CHANNELS; c++) begin
         if ((LAST_CH - byte_idx) == 3'(c)) begin
            pix_byte = pix_lat[c*CH_W + CH_W - 8 +: 8];
         end
      end
   end

   // The sync word and the checksum byte itself are excluded from the sum
   always_comb begin
      send_byte = checksum;
      sum_en    = 1'b0;
      case (cur_state)
         S_HDR: begin
            send_byte = hdr_byte;
            sum_en    = (byte_idx >= 3'd2);
         end
         S_PIX: begin
            send_byte = pix_byte;
            sum_en    = 1'b1;
         end
         default: begin
            send_byte = checksum;
            sum_en    = 1'b0;
         end
      endcase
   end

   assign keep_pix = ((col & DMASK) == 16'd0) && ((row & DMASK) == 16'd0);
   assign at_last  = (col == LAST_COL) && (row == LAST_ROW);

   // Main sequencer. FETCH takes two cycles per pixel: latch with pix_ready high,
   // then classify, so the source never sees ready against a stale pixel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_state   <= S_IDLE;
         ret_state   <= S_IDLE;
         row         <= 16'd0;
         col         <= 16'd0;
         byte_idx    <= 3'd0;
         checksum    <= 8'd0;
         pix_lat     <= '0;
         last_pix    <= 1'b0;
         start_armed <= 1'b1;
         tx_data     <= 8'd0;
         tx_start    <= 1'b0;
         pix_ready   <= 1'b0;
         frame_done  <= 1'b0;
      end else begin
         tx_start   <= 1'b0;
         pix_ready  <= 1'b0;
         frame_done <= 1'b0;
         if (abort && (cur_state != S_IDLE)) begin
            cur_state <= S_IDLE;
         end else begin
            case (cur_state)
               S_IDLE: begin
                  if (!start) begin
                     start_armed <= 1'b1;
                  end
                  if (start && !abort && start_armed) begin
                     start_armed <= 1'b0;
                     row         <= 16'd0;
                     col         <= 16'd0;
                     byte_idx    <= 3'd0;
                     checksum    <= 8'd0;
                     last_pix    <= 1'b0;
                     cur_state   <= S_HDR;
                  end
               end
               S_HDR, S_PIX, S_CSUM: begin
                  if (!tx_busy) begin
                     tx_data   <= send_byte;
                     tx_start  <= 1'b1;
                     ret_state <= cur_state;
                     cur_state <= S_WAIT;
                     if (sum_en) begin
                        checksum <= checksum + send_byte;
                     end
                  end
               end
               S_FETCH: begin
                  if (pix_ready) begin
                     if (col == LAST_COL) begin
                        col <= 16'd0;
                        row <= row + 16'd1;
                     end else begin
                        col <= col + 16'd1;
                     end
                     if (keep_pix) begin
                        last_pix  <= at_last;
                        byte_idx  <= 3'd0;
                        cur_state <= S_PIX;
                     end else if (at_last) begin
                        cur_state <= S_CSUM;
                     end
                  end else if (pix_valid) begin
                     pix_lat   <= pix_data;
                     pix_ready <= 1'b1;
                  end
               end
               S_WAIT: begin
                  if (tx_done && !tx_start) begin
                     case (ret_state)
                        S_HDR: begin
                           if (byte_idx == 3'd6) begin
                              byte_idx  <= 3'd0;
                              cur_state <= S_FETCH;
                           end else begin
                              byte_idx  <= byte_idx + 3'd1;
                              cur_state <= S_HDR;
                           end
                        end
                        S_PIX: begin
                           if (byte_idx == LAST_CH) begin
                              byte_idx  <= 3'd0;
                              cur_state <= last_pix ? S_CSUM : S_FETCH;
                           end else begin
                              byte_idx  <= byte_idx + 3'd1;
                              cur_state <= S_PIX;
                           end
                        end
                        default: begin
                           frame_done <= 1'b1;
                           cur_state  <= S_DONE;
                        end
                     endcase
                  end
               end
               S_DONE: begin
                  cur_state <= S_IDLE;
               end
               default: begin
                  cur_state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_frame_uart_streamer.sv
// Randomised bench for frame_uart_streamer: a 4x2 frame through a full-rate (DECIM=1)
// and a decimating (DECIM=2) instance, with a packet-level reference model.
module tb_frame_uart_streamer;

   localparam int W    = 4;
   localparam int H    = 2;
   localparam int CH   = 3;
   localparam int CW   = 10;
   localparam int NPIX = W * H;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start_a = 1'b0;
   logic start_b = 1'b0;
   logic abort = 1'b0;
   logic pix_valid = 1'b0;
   logic tx_busy = 1'b0;
   logic tx_done = 1'b0;
   logic [CH*CW-1:0] pix_data = '0;

   logic       pr_a, txs_a, busy_a, fd_a;
   logic [7:0] txd_a;
   logic [2:0] st_a;
   logic       pr_b, txs_b, busy_b, fd_b;
   logic [7:0] txd_b;
   logic [2:0] st_b;

   logic       sel = 1'b0;
   logic       m_pix_ready, m_tx_start, m_busy, m_frame_done;
   logic [7:0] m_tx_data;
   logic [2:0] m_state;

   assign m_pix_ready  = sel ? pr_b   : pr_a;
   assign m_tx_start   = sel ? txs_b  : txs_a;
   assign m_busy       = sel ? busy_b : busy_a;
   assign m_frame_done = sel ? fd_b   : fd_a;
   assign m_tx_data    = sel ? txd_b  : txd_a;
   assign m_state      = sel ? st_b   : st_a;

   always #5 clk = ~clk;

   frame_uart_streamer #(.WIDTH(W), .HEIGHT(H), .CHANNELS(CH), .CH_W(CW), .DECIM(1)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .abort(abort),
      .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pr_a),
      .tx_data(txd_a), .tx_start(txs_a), .tx_busy(tx_busy), .tx_done(tx_done),
      .busy(busy_a), .frame_done(fd_a), .state(st_a)
   );

   frame_uart_streamer #(.WIDTH(W), .HEIGHT(H), .CHANNELS(CH), .CH_W(CW), .DECIM(2)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .abort(abort),
      .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pr_b),
      .tx_data(txd_b), .tx_start(txs_b), .tx_busy(tx_busy), .tx_done(tx_done),
      .busy(busy_b), .frame_done(fd_b), .state(st_b)
   );

   int tests_run = 0;
   int fails = 0;
   int nstart, nready, ndone, viol_busy, viol_stable, viol_ready;
   logic prev_start = 1'b0;
   logic [7:0] byte_q[$];
   logic [7:0] exp_q[$];
   logic [CH*CW-1:0] frame_pix [NPIX];
   int src_idx = 0;
   int gap = 0;
   int max_gap = 0;
   int extra_busy = 0;
   logic src_en = 1'b0;
   logic fire;
   logic [7:0] held;

   // Event counters and protocol violations seen on the selected instance
   always @(negedge clk) begin
      if (m_tx_start) begin
         nstart++;
         if (tx_busy || prev_start) viol_busy++;
      end
      prev_start = m_tx_start;
      if (m_pix_ready) begin
         nready++;
         if (m_state !== 3'd2) viol_ready++;
      end
      if (m_frame_done) ndone++;
   end

   // UART model: 5 busy cycles per byte, optional extra busy time after each tx_done
   always begin
      @(negedge clk);
      if (m_tx_start && !rst) begin
         held = m_tx_data;
         byte_q.push_back(held);
         @(posedge clk); #1 tx_busy = 1'b1;
         repeat (5) begin
            @(negedge clk);
            if (m_state == 3'd5 && m_tx_data !== held) viol_stable++;
            @(posedge clk); #1;
         end
         tx_done = 1'b1;
         tx_busy = (extra_busy > 0);
         @(negedge clk);
         if (m_state == 3'd5 && m_tx_data !== held) viol_stable++;
         @(posedge clk); #1 tx_done = 1'b0;
         if (extra_busy > 0) begin
            repeat (extra_busy - 1) @(posedge clk);
            #1 tx_busy = 1'b0;
         end
      end
   end

   // Pixel source with optional random idle gaps between pixels
   always begin
      @(negedge clk);
      fire = pix_valid && m_pix_ready;
      @(posedge clk); #1;
      if (fire) begin
         src_idx++;
         gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      end
      if (!src_en || src_idx >= NPIX) begin
         pix_valid = 1'b0;
      end else if (gap > 0) begin
         pix_valid = 1'b0;
         gap--;
      end else begin
         pix_valid = 1'b1;
         pix_data  = frame_pix[src_idx];
      end
   end

   // mode 0 random pixels, 1 every channel 10'h040, 2 pixel index in top byte, 3 reuse last frame
   task automatic launch_frame(input logic use_b, input int mode, input int gaps,
                               input int stall, input logic hold_start);
      int d, ow, oh, sum;
      logic [31:0] r32;
      logic [CH*CW-1:0] px;
      d = use_b ? 2 : 1;
      for (int i = 0; i < NPIX; i++) begin
         r32 = $urandom;
         case (mode)
            0: frame_pix[i] = r32[CH*CW-1:0];
            1: frame_pix[i] = {CH{10'h040}};
            2: frame_pix[i] = {CH{10'(i * 4)}};
            default: ;
         endcase
      end
      exp_q.delete();
      ow = W / d;
      oh = H / d;
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h5A);
      exp_q.push_back(8'(ow >> 8));
      exp_q.push_back(8'(ow));
      exp_q.push_back(8'(oh >> 8));
      exp_q.push_back(8'(oh));
      exp_q.push_back(8'(CH));
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            if (r % d == 0 && c % d == 0)
               for (int ch = CH - 1; ch >= 0; ch--) begin
                  px = frame_pix[r*W + c];
                  exp_q.push_back(8'(px >> (ch*CW + CW - 8)));
               end
      sum = 0;
      for (int i = 2; i < exp_q.size(); i++) sum += int'(exp_q[i]);
      exp_q.push_back(8'(sum));

      @(negedge clk);
      sel = use_b;
      byte_q.delete();
      nstart = 0; nready = 0; ndone = 0;
      viol_busy = 0; viol_stable = 0; viol_ready = 0;
      src_idx = 0; gap = 0; max_gap = gaps; extra_busy = stall; src_en = 1'b1;
      if (stall > 0) tx_busy = 1'b1;
      if (use_b) start_b = 1'b1; else start_a = 1'b1;
      @(negedge clk);
      if (!hold_start) begin
         start_a = 1'b0;
         start_b = 1'b0;
      end
      if (stall > 0) begin
         repeat (stall - 1) @(negedge clk);
         tx_busy = 1'b0;
      end
   endtask

   task automatic check_frame(input string tag);
      int i;
      for (i = 0; i < 8000; i++) begin
         if (ndone != 0) break;
         @(posedge clk);
      end
      repeat (30) @(posedge clk);
      src_en = 1'b0;
      tests_run++;
      if (ndone !== 1) begin
         fails++;
         $display("[TB] FAIL %s frame_done count: got %0d expected 1", tag, ndone);
      end
      tests_run++;
      if (byte_q.size() != exp_q.size()) begin
         fails++;
         $display("[TB] FAIL %s byte count: got %0d expected %0d", tag, byte_q.size(), exp_q.size());
      end
      for (int k = 0; k < exp_q.size() && k < byte_q.size(); k++) begin
         tests_run++;
         if (byte_q[k] !== exp_q[k]) begin
            fails++;
            $display("[TB] FAIL %s byte[%0d]: got %02h expected %02h", tag, k, byte_q[k], exp_q[k]);
         end
      end
      tests_run++;
      if (nready !== NPIX) begin
         fails++;
         $display("[TB] FAIL %s pix_ready pulses: got %0d expected %0d", tag, nready, NPIX);
      end
      tests_run++;
      if (viol_busy !== 0 || viol_stable !== 0 || viol_ready !== 0) begin
         fails++;
         $display("[TB] FAIL %s protocol: busy/start %0d, data unstable %0d, ready outside FETCH %0d, expected 0/0/0",
                  tag, viol_busy, viol_stable, viol_ready);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      tests_run++;
      if ({st_a, busy_a, txs_a, pr_a, fd_a, txd_a} !== 14'd0) begin
         fails++;
         $display("[TB] FAIL reset dut_a: state %0d busy %b start %b ready %b done %b data %02h, expected all 0",
                  st_a, busy_a, txs_a, pr_a, fd_a, txd_a);
      end
      tests_run++;
      if ({st_b, busy_b, txs_b, pr_b, fd_b, txd_b} !== 14'd0) begin
         fails++;
         $display("[TB] FAIL reset dut_b: state %0d busy %b, expected 0", st_b, busy_b);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      tests_run++;
      if (st_a !== 3'd0 || busy_a !== 1'b0) begin
         fails++;
         $display("[TB] FAIL idle after reset: state %0d busy %b expected 0 0", st_a, busy_a);
      end
   endtask

   task automatic test_fixed_frame();
      launch_frame(1'b0, 1, 0, 0, 1'b0);
      check_frame("fixed");
      tests_run++;
      if (byte_q.size() != 32 || byte_q[31] !== 8'h89 || byte_q[7] !== 8'h10) begin
         fails++;
         $display("[TB] FAIL fixed packet: got %0d bytes, expected 32 with payload 10 and checksum 89",
                  byte_q.size());
      end
   endtask

   task automatic test_decim();
      logic [7:0] want [14] = '{8'hA5, 8'h5A, 8'h00, 8'h02, 8'h00, 8'h01, 8'h03,
                                8'h00, 8'h00, 8'h00, 8'h02, 8'h02, 8'h02, 8'h0C};
      launch_frame(1'b1, 2, 0, 0, 1'b0);
      check_frame("decim");
      for (int k = 0; k < 14 && k < byte_q.size(); k++) begin
         tests_run++;
         if (byte_q[k] !== want[k]) begin
            fails++;
            $display("[TB] FAIL decim fixed byte[%0d]: got %02h expected %02h", k, byte_q[k], want[k]);
         end
      end
      launch_frame(1'b1, 0, 0, 0, 1'b0);
      check_frame("decim_rand");
   endtask

   task automatic test_busy_stall();
      launch_frame(1'b0, 0, 0, 20, 1'b0);
      check_frame("stall");
      extra_busy = 0;
   endtask

   task automatic test_gaps();
      logic [7:0] ref_q[$];
      launch_frame(1'b0, 0, 0, 0, 1'b0);
      check_frame("nogap");
      ref_q = byte_q;
      launch_frame(1'b0, 3, 10, 0, 1'b0);
      check_frame("gap");
      tests_run++;
      if (byte_q != ref_q) begin
         fails++;
         $display("[TB] FAIL gap stream: got %0d bytes differing from %0d-byte no-gap stream",
                  byte_q.size(), ref_q.size());
      end
      launch_frame(1'b1, 0, 10, 0, 1'b0);
      check_frame("gap_decim");
   endtask

   task automatic test_start_held();
      int snap;
      launch_frame(1'b0, 0, 0, 0, 1'b1);
      check_frame("held");
      snap = nstart;
      repeat (50) @(posedge clk);
      tests_run++;
      if (nstart !== snap || m_state !== 3'd0) begin
         fails++;
         $display("[TB] FAIL held start retrigger: starts %0d state %0d, expected %0d and 0",
                  nstart, m_state, snap);
      end
      start_a = 1'b0;
   endtask

   task automatic test_abort();
      int i, s_start, s_ready;
      launch_frame(1'b0, 0, 0, 0, 1'b0);
      for (i = 0; i < 2000; i++) begin
         @(posedge clk); #1;
         if (nstart >= 10) break;
      end
      tests_run++;
      if (nstart < 10) begin
         fails++;
         $display("[TB] FAIL abort timeout: got %0d tx_start, expected 10", nstart);
      end
      abort = 1'b1;
      @(posedge clk); #1;
      tests_run++;
      if (m_state !== 3'd0 || m_busy !== 1'b0 || m_tx_start !== 1'b0 || m_pix_ready !== 1'b0) begin
         fails++;
         $display("[TB] FAIL abort response: state %0d busy %b start %b ready %b, expected 0 0 0 0",
                  m_state, m_busy, m_tx_start, m_pix_ready);
      end
      @(posedge clk); #1 abort = 1'b0;
      s_start = nstart;
      s_ready = nready;
      repeat (60) @(posedge clk);
      src_en = 1'b0;
      tests_run++;
      if (nstart !== s_start || nready !== s_ready || ndone !== 0) begin
         fails++;
         $display("[TB] FAIL after abort: starts %0d ready %0d done %0d, expected %0d %0d 0",
                  nstart, nready, ndone, s_start, s_ready);
      end
      launch_frame(1'b0, 0, 0, 0, 1'b0);
      check_frame("post_abort");
   endtask

   task automatic test_async_reset();
      int i;
      launch_frame(1'b0, 0, 0, 0, 1'b0);
      for (i = 0; i < 2000; i++) begin
         @(posedge clk); #1;
         if (nstart >= 12 && m_state == 3'd5) break;
      end
      tests_run++;
      if (nstart < 12) begin
         fails++;
         $display("[TB] FAIL reset timeout: got %0d tx_start, expected 12", nstart);
      end
      @(negedge clk); #2 rst = 1'b1;
      #1;
      tests_run++;
      if ({st_a, busy_a, txs_a, pr_a, fd_a, txd_a} !== 14'd0) begin
         fails++;
         $display("[TB] FAIL async reset: state %0d busy %b start %b ready %b done %b data %02h, expected all 0",
                  st_a, busy_a, txs_a, pr_a, fd_a, txd_a);
      end
      src_en = 1'b0;
      repeat (40) @(posedge clk);
      #1 rst = 1'b0;
      launch_frame(1'b0, 0, 0, 0, 1'b0);
      check_frame("post_reset");
   endtask

   initial begin
      test_reset();
      test_fixed_frame();
      test_decim();
      test_busy_stall();
      test_gaps();
      test_start_held();
      test_abort();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule

// File: doc/frame_uart_streamer.md
Name: frame_uart_streamer

Overview:
- Parametrised successor to the single-frame RGB-over-UART sender. Consumes a raster pixel stream (WIDTH x HEIGHT, CHANNELS channels of CH_W bits) from the RAW-to-RGB stage through a valid/ready handshake.
- Optionally decimates the frame spatially and serialises it over the UART transmitter byte interface.
- Wraps each frame in a framed packet: sync word, dimension header, payload, checksum.
- Sits between the colour-conversion pipeline and the uart_tx block, under control of the door-monitor host FSM.

Parameters:
- WIDTH, 640, input frame width in pixels (1..65535)
- HEIGHT, 480, input frame height in pixels (1..65535)
- CHANNELS, 3, colour channels per pixel (1..4)
- CH_W, 10, bits per channel on pix_data (8..16)
- DECIM, 1, spatial decimation factor (1, 2, 4 or 8); must divide WIDTH and HEIGHT

Ports:
- clk  in  1  single system clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  level; sampled in IDLE, begins one frame packet
- abort  in  1  level; cancels the frame in progress
- pix_data  in  CHANNELS*CH_W  pixel; channel CHANNELS-1 in the MSBs
- pix_valid  in  1  pix_data valid
- pix_ready  out  1  one-cycle pulse; pixel consumed this cycle
- tx_data  out  8  byte to UART
- tx_start  out  1  one-cycle request to UART
- tx_busy  in  1  UART transmitting
- tx_done  in  1  one-cycle pulse; byte finished
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse when checksum byte completes
- state  out  3  current state code (debug)

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; tx_data=0, tx_start=0, pix_ready=0, busy=0, frame_done=0.
  - All counters and the checksum are cleared.
  - A reset mid-frame drops the frame silently; no frame_done.
- State codes: IDLE=0, HDR=1, FETCH=2, PIX=3, CSUM=4, WAIT=5, DONE=6.
- Byte send rule, identical in HDR/PIX/CSUM:
  - tx_data is loaded, then tx_start is pulsed for exactly one cycle, only when tx_busy=0.
  - The FSM then sits in WAIT until tx_done=1. tx_data is held stable from the start pulse until tx_done.
  - tx_done arriving in the same cycle as tx_start is ignored.
- IDLE -> HDR when start=1 and abort=0. Clears row/col counters and the checksum.
- HDR sends 7 bytes in order:
  - 0xA5, 0x5A, OW[15:8], OW[7:0], OH[15:8], OH[7:0], CHANNELS.
  - OW = WIDTH/DECIM and OH = HEIGHT/DECIM, computed at elaboration.
- HDR -> FETCH after the 7th tx_done.
- FETCH:
  - Waits for pix_valid. When pix_valid=1, pix_ready pulses for one cycle and the pixel is latched.
  - The pixel is kept if (col % DECIM == 0) and (row % DECIM == 0). Kept pixels go to PIX; others are discarded and the FSM stays in FETCH.
  - col counts to WIDTH-1, then wraps to 0 and row increments. After the pixel at (WIDTH-1, HEIGHT-1) is consumed, the FSM exits to CSUM or PIX.
- PIX:
  - Sends CHANNELS bytes, channel CHANNELS-1 first. Each byte is the top 8 bits of its channel ([CH_W-1:CH_W-8]).
  - Returns to FETCH, or to CSUM if that was the last consumed pixel of the frame.
- Checksum:
  - 8-bit sum modulo 256 of every byte after the sync word (header bytes 3..7 plus all payload bytes).
  - Accumulated when each byte's tx_start is issued.
- CSUM sends the checksum byte, then DONE.
- DONE: frame_done pulses for one cycle, then IDLE.
  - start still high does not retrigger until it has been seen low once in IDLE.
- abort=1 in any non-IDLE state goes to IDLE next cycle:
  - tx_start and pix_ready are forced to 0; no frame_done.
  - Any byte already started completes in the UART; its tx_done is ignored.
  - abort and start both high in IDLE: abort wins.
- pix_ready never pulses outside FETCH. Exactly WIDTH*HEIGHT pulses occur per completed frame.
- Counters: row/col 16 bits; byte index 3 bits; checksum 8 bits wrapping.

Test Plan:
- WIDTH=4, HEIGHT=2, CHANNELS=3, CH_W=10, DECIM=1; every pixel 10'h040 on all channels; UART model takes 5 cycles per byte.
  -> Bytes: A5 5A 00 04 00 02 03, then 24x 0x10, then checksum 0x89.
  -> 8 pix_ready pulses; one frame_done.
- Same frame with DECIM=2; pixels numbered 0..7 in raster order.
  -> Header 00 02 00 01 03; only pixels 0 and 2 transmitted (6 payload bytes).
  -> 8 pix_ready pulses; checksum equals the mod-256 sum of the bytes sent.
- tx_busy held high for 20 cycles before each byte.
  -> tx_start never asserted while tx_busy=1; tx_data stable from each start to its tx_done; byte stream unchanged.
- pix_valid low for random 0..10-cycle gaps.
  -> FSM waits in FETCH with no pix_ready; output identical to the no-gap run.
- abort asserted during the 3rd payload byte.
  -> IDLE next cycle, busy=0, no frame_done, no further tx_start or pix_ready.
  -> A following start sends a fresh, correct packet.
- rst pulsed asynchronously mid-WAIT.
  -> All outputs go to their reset values immediately, without waiting for a clk edge; a subsequent frame is correct.
